ones_comp_checksum: RTL and testbench
=====================================

// Module: ones_comp_checksum
// PURPOSE
//  Downstream consumer of the 4-bit ones'-complement adder path. Accepts a stream
//  of WIDTH-bit words over valid/ready and accumulates them with end-around carry
//  into a running ones'-complement sum. On the last word of a frame it presents the
//  sum, its complement (checksum) and the word count over a second valid/ready port.
// PARAMETERS
//  WIDTH  4  data word width in bits
//  CNT_W  8  width of the frame word counter
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        synchronous reset, active-low
//  in_valid   in   1        input word valid
//  in_ready   out  1        block can accept a word
//  in_data    in   WIDTH    input word
//  in_last    in   1        word is last of frame; qualified by in_valid
//  out_valid  out  1        frame result valid
//  out_ready  in   1        consumer accepts result
//  out_sum    out  WIDTH    ones'-complement sum of the frame
//  out_chk    out  WIDTH    ~out_sum (checksum)
//  out_count  out  CNT_W    words in frame, saturating at 2^CNT_W-1
//  out_ovf    out  1        1 if the word count saturated
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=ACC, acc=0, cnt=0, ovf=0, in_ready=1,
//    out_valid=0, out_sum=0, out_chk=all ones, out_count=0, out_ovf=0.
//  - Input handshake: word accepted on posedge where in_valid & in_ready.
//    Output handshake: result consumed on posedge where out_valid & out_ready.
//  - Add rule: s = {1'b0,acc} + {1'b0,in_data} (WIDTH+1 bits);
//    acc_next = s[WIDTH-1:0] + s[WIDTH]. The second add never carries out.
//  - Negative zero (all ones) is kept; no normalisation to 0.
//  - FSM ACC: in_ready=1, out_valid=0. On accept: acc<=acc_next;
//    cnt<=cnt+1 (saturates, ovf<=1 if already at max). If in_last: latch
//    out_sum=acc_next, out_chk=~acc_next, out_count, out_ovf -> HOLD.
//  - FSM HOLD: in_ready=0, out_valid=1, outputs stable. On out_ready: acc=0,
//    cnt=0, ovf=0 -> ACC. A new word is accepted no earlier than the cycle after.
//  - Latency: out_valid rises on the cycle after the last word is accepted.
//    Throughput: one word per cycle in ACC; one cycle of in_ready=0 per frame min.
//  - A single-word frame (first word has in_last=1) yields sum = that word.
//  - in_valid=0 in ACC: state held. out_ready with out_valid=0: ignored.
//  - Reset mid-frame or in HOLD discards partial sum and pending result;
//    all outputs return to their reset values the next cycle.
//  - out_sum, out_chk, out_count, out_ovf are registered; only change on entry
//    to HOLD or on reset.
// TESTING
//  1. Frame 5,3(last) -> out_sum=8, out_chk=7, out_count=2, out_ovf=0, one cycle after.
//  2. Frame 9,A(last): 9+A=0x13 -> end-around -> out_sum=4, out_chk=B.
//  3. Frame F,1(last) -> out_sum=1; frame F,0(last) -> out_sum=F (neg zero kept).
//  4. Backpressure: out_ready=0 for 5 cycles after frame 9,A -> out_valid stays 1,
//     in_ready=0, out_sum=4 stable; next frame 2(last) -> out_sum=2 (acc cleared).
//  5. 300 words of 1 then last: out_count=255, out_ovf=1; sum per ones' rules.
//  6. rst_n=0 after 2 words of frame 7,7,7(last) -> after reset, frame 1(last)
//     gives out_sum=1, out_count=1; no stale result ever asserts out_valid.

Source files
------------

// File: rtl/ones_comp_checksum.sv
// Ones'-complement frame accumulator with end-around carry.
// Presents sum, checksum and word count once per frame.
module ones_comp_checksum #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [WIDTH-1:0] out_chk,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    typedef enum logic {
        ST_ACC,
        ST_HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] chk_q, chk_d;
    logic [CNT_W-1:0] ocnt_q, ocnt_d;
    logic             oovf_q, oovf_d;

    logic [WIDTH:0]   add_s;
    logic [WIDTH-1:0] acc_add;
    logic             cnt_max;
    logic [CNT_W-1:0] cnt_inc;
    logic             ovf_inc;
    logic             in_fire;
    logic             out_fire;

    // End-around carry: the carry out folds back into bit 0.
    // The fold cannot carry again, so negative zero survives.
    assign add_s   = {1'b0, acc_q} + {1'b0, in_data};
    assign acc_add = add_s[WIDTH-1:0]
                   + {{(WIDTH-1){1'b0}}, add_s[WIDTH]};

    assign cnt_max = &cnt_q;
    assign cnt_inc = cnt_max ? cnt_q : cnt_q + CNT_W'(1);
    assign ovf_inc = ovf_q | cnt_max;

    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_HOLD);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    assign out_sum   = sum_q;
    assign out_chk   = chk_q;
    assign out_count = ocnt_q;
    assign out_ovf   = oovf_q;

    // Next-state: accumulate in ACC, latch result on last word, clear on consume.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        sum_d   = sum_q;
        chk_d   = chk_q;
        ocnt_d  = ocnt_q;
        oovf_d  = oovf_q;
        unique case (state_q)
            ST_ACC: begin
                if (in_fire) begin
                    acc_d = acc_add;
                    cnt_d = cnt_inc;
                    ovf_d = ovf_inc;
                    if (in_last) begin
                        sum_d   = acc_add;
                        chk_d   = ~acc_add;
                        ocnt_d  = cnt_inc;
                        oovf_d  = ovf_inc;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (out_fire) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            sum_q   <= '0;
            chk_q   <= '1;
            ocnt_q  <= '0;
            oovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            sum_q   <= sum_d;
            chk_q   <= chk_d;
            ocnt_q  <= ocnt_d;
            oovf_q  <= oovf_d;
        end
    end

endmodule

// File: tb/tb_ones_comp_checksum.sv
// Bench for ones_comp_checksum: directed frames plus random frames
// checked against an arithmetic ones'-complement reference.
module tb_ones_comp_checksum;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_sum;
    logic [3:0] out_chk;
    logic [7:0] out_count;
    logic       out_ovf;

    int errors = 0;
    int checks = 0;

    ones_comp_checksum #(.WIDTH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_chk   (out_chk),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    // Reference: integer total folded mod 15 into 1..15; zero only if all zero.
    function automatic logic [3:0] ref_sum(input logic [3:0] w[$]);
        int t = 0;
        foreach (w[i]) t += int'(w[i]);
        while (t > 15) t = (t & 15) + (t >> 4);
        return 4'(t);
    endfunction

    function automatic logic [17:0] ref_res(input logic [3:0] w[$]);
        logic [3:0] s;
        logic [7:0] c;
        s = ref_sum(w);
        c = (w.size() > 255) ? 8'd255 : 8'(w.size());
        return {1'b1, s, ~s, c, (w.size() > 255)};
    endfunction

    function automatic logic [17:0] obs();
        return {out_valid, out_sum, out_chk, out_count, out_ovf};
    endfunction

    // Drive words; in_last on final word when fin=1. gap>0 inserts idle cycles.
    task automatic send(input logic [3:0] w[$], input bit fin,
                        input int gap, output bit ok);
        ok = 1'b1;
        foreach (w[i]) begin
            int n = 0;
            if (gap > 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(gap, 0)) @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = w[i];
            in_last  = fin && (i == w.size() - 1);
            while (!in_ready && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (n >= 50) ok = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 4'h0;
    endtask

    task automatic consume(input int delay, output bit ok);
        int n = 0;
        repeat (delay) @(posedge clk);
        #1;
        out_ready = 1'b1;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        ok = (n < 50);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if ({in_ready, obs()} !== {1'b1, 1'b0, 4'h0, 4'hF, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset: got %h want %h", {in_ready, obs()},
                     {1'b1, 1'b0, 4'h0, 4'hF, 8'd0, 1'b0});
        end
    endtask

    task automatic test_basic();
        logic [3:0] f[4][$];
        logic [17:0] want[4];
        bit ok;
        f[0] = '{4'h5, 4'h3};
        f[1] = '{4'h9, 4'hA};
        f[2] = '{4'hF, 4'h1};
        f[3] = '{4'hF, 4'h0};
        want[0] = {1'b1, 4'h8, 4'h7, 8'd2, 1'b0};
        want[1] = {1'b1, 4'h4, 4'hB, 8'd2, 1'b0};
        want[2] = {1'b1, 4'h1, 4'hE, 8'd2, 1'b0};
        want[3] = {1'b1, 4'hF, 4'h0, 8'd2, 1'b0};
        for (int k = 0; k < 4; k++) begin
            send(f[k], 1'b1, 0, ok);
            checks++;
            if (!ok || obs() !== want[k]) begin
                errors++;
                $display("FAIL basic%0d: got %h want %h ok=%0d",
                         k, obs(), want[k], ok);
            end
            consume(0, ok);
            checks++;
            if (!ok || out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL consume%0d: valid=%b ready=%b want 0/1",
                         k, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] f[$];
        bit ok;
        f = '{4'h9, 4'hA};
        send(f, 1'b1, 0, ok);
        in_valid = 1'b1;
        in_data  = 4'h7;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (!ok || {in_ready, obs()} !==
                {1'b0, 1'b1, 4'h4, 4'hB, 8'd2, 1'b0}) begin
                errors++;
                $display("FAIL hold%0d: got %h want %h", c,
                         {in_ready, obs()},
                         {1'b0, 1'b1, 4'h4, 4'hB, 8'd2, 1'b0});
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        consume(0, ok);
        f = '{4'h2};
        send(f, 1'b1, 0, ok);
        checks++;
        if (!ok || obs() !== {1'b1, 4'h2, 4'hD, 8'd1, 1'b0}) begin
            errors++;
            $display("FAIL after_hold: got %h want %h",
                     obs(), {1'b1, 4'h2, 4'hD, 8'd1, 1'b0});
        end
        consume(1, ok);
    endtask

    task automatic test_saturate();
        logic [3:0] f[$];
        bit ok;
        for (int i = 0; i < 301; i++) f.push_back(4'h1);
        send(f, 1'b1, 0, ok);
        checks++;
        if (!ok || obs() !== ref_res(f) ||
            obs() !== {1'b1, 4'h1, 4'hE, 8'd255, 1'b1}) begin
            errors++;
            $display("FAIL saturate: got %h want %h", obs(),
                     {1'b1, 4'h1, 4'hE, 8'd255, 1'b1});
        end
        consume(0, ok);
        f = '{4'h3};
        send(f, 1'b1, 0, ok);
        checks++;
        if (!ok || obs() !== {1'b1, 4'h3, 4'hC, 8'd1, 1'b0}) begin
            errors++;
            $display("FAIL ovf_clear: got %h want %h", obs(),
                     {1'b1, 4'h3, 4'hC, 8'd1, 1'b0});
        end
        consume(0, ok);
    endtask

    task automatic test_reset_mid();
        logic [3:0] f[$];
        bit ok;
        bit seen = 1'b0;
        f = '{4'h7, 4'h7};
        send(f, 1'b0, 0, ok);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'h7;
        in_last  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst_n    = 1'b1;
        checks++;
        if ({in_ready, obs()} !== {1'b1, 1'b0, 4'h0, 4'hF, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid: got %h want %h", {in_ready, obs()},
                     {1'b1, 1'b0, 4'h0, 4'hF, 8'd0, 1'b0});
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL stale_valid: got 1 want 0");
        end
        f = '{4'h1};
        send(f, 1'b1, 0, ok);
        checks++;
        if (!ok || obs() !== {1'b1, 4'h1, 4'hE, 8'd1, 1'b0}) begin
            errors++;
            $display("FAIL post_reset: got %h want %h", obs(),
                     {1'b1, 4'h1, 4'hE, 8'd1, 1'b0});
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if ({in_ready, obs()} !== {1'b1, 1'b0, 4'h0, 4'hF, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_hold: got %h want %h", {in_ready, obs()},
                     {1'b1, 1'b0, 4'h0, 4'hF, 8'd0, 1'b0});
        end
    endtask

    task automatic test_random();
        logic [3:0] f[$];
        bit ok;
        bit ok2;
        for (int k = 0; k < 25; k++) begin
            f = {};
            repeat ($urandom_range(12, 1)) f.push_back(4'($urandom));
            out_ready = 1'b1;
            send(f, 1'b1, (k % 2) * 3, ok);
            out_ready = 1'b0;
            checks++;
            if (!ok || obs() !== ref_res(f)) begin
                errors++;
                $display("FAIL random%0d: got %h want %h n=%0d",
                         k, obs(), ref_res(f), f.size());
            end
            consume($urandom_range(3, 0), ok2);
            if (!ok2) begin
                checks++;
                errors++;
                $display("FAIL random_consume%0d: timeout", k);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
